// File: rtl/fir_stim_pkg.sv
// Shared encodings and ROM-content helper for the FIR stimulus generator.
package fir_stim_pkg;

  typedef enum logic [1:0] {
    MODE_IMPULSE = 2'b00,
    MODE_STEP    = 2'b01,
    MODE_TONE    = 2'b10,
    MODE_CHIRP   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int unsigned     DEF_DATA_WIDTH = 18;
  localparam longint unsigned A_FULL         = (64'd1 << (DEF_DATA_WIDTH - 1)) - 64'd1;
  localparam logic [63:0]     PI_Q60         = 64'h3243_F6A8_885A_308D;

  // round(A*sin(pi*(2*idx+1)/(4*2^addr_bits))) via a Q60 fixed-point Taylor series,
  // evaluated only at elaboration time.
  function automatic longint unsigned qlut_entry(input int unsigned idx,
                                                 input int unsigned addr_bits,
                                                 input int unsigned dw);
    logic [127:0] x, x2, term, pos, neg, amp, prod;
    x    = (128'(PI_Q60) * 128'(2 * idx + 1)) >> (addr_bits + 2);
    x2   = (x * x) >> 60;
    term = x;
    pos  = x;
    neg  = '0;
    for (int unsigned n = 1; n < 16; n++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n % 2 == 1) neg = neg + term;
      else            pos = pos + term;
    end
    if (dw <= DEF_DATA_WIDTH) amp = 128'(A_FULL >> (DEF_DATA_WIDTH - dw));
    else                      amp = (128'd1 << (dw - 1)) - 128'd1;
    prod = amp * (pos - neg) + (128'd1 << 59);
    return 64'(prod >> 60);
  endfunction

endpackage

// File: rtl/fir_stim_gen_sine_qlut.sv
// Registered quarter-wave sine magnitude ROM.
module sine_qlut
  import fir_stim_pkg::*;
#(
  parameter int unsigned LUT_ADDR   = 8,
  parameter int unsigned DATA_WIDTH = 18
) (
  input  logic                  i_clk,
  input  logic [LUT_ADDR-1:0]   i_addr,
  output logic [DATA_WIDTH-2:0] o_mag
);

  localparam int unsigned N = 1 << LUT_ADDR;

  logic [DATA_WIDTH-2:0] rom [N];

  // Contents are elaboration-time constants, so this folds to a plain ROM.
  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam longint unsigned V = qlut_entry(g, LUT_ADDR, DATA_WIDTH);
    assign rom[g] = V[DATA_WIDTH-2:0];
  end

  always_ff @(posedge i_clk) begin
    o_mag <= rom[i_addr];
  end

endmodule

// File: rtl/fir_stim_gen.sv
// Burst sample source (impulse/step/tone/chirp) feeding the FIR data input.
module fir_stim_gen
  import fir_stim_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 18,
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned LUT_ADDR    = 8,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                         i_clk,
  input  logic                         i_clr,
  input  logic                         i_ce,
  input  logic                         i_start,
  input  logic [1:0]                   i_mode,
  input  logic signed [DATA_WIDTH-1:0] i_amp,
  input  logic [PHASE_WIDTH-1:0]       i_finc,
  input  logic [PHASE_WIDTH-1:0]       i_fstep,
  input  logic [LEN_WIDTH-1:0]         i_len,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_done
);

  state_t                         state;
  mode_t                          mode;
  logic signed [DATA_WIDTH-1:0]   amp;
  logic [PHASE_WIDTH-1:0]         phase, finc, fstep;
  logic [LEN_WIDTH-1:0]           len, k;

  logic                           issue, is_last, zero_start;
  logic [1:0]                     quad;
  logic [LUT_ADDR-1:0]            idx, addr;
  logic [DATA_WIDTH-2:0]          mag;
  logic signed [DATA_WIDTH-1:0]   lvl, sine_val;

  logic                           s1_valid, s1_last, s1_sine, s1_neg;
  logic signed [DATA_WIDTH-1:0]   s1_lvl;

  always_comb begin
    issue      = (state == ST_RUN) && i_ce;
    is_last    = (k == len - LEN_WIDTH'(1));
    zero_start = (state == ST_IDLE) && i_start && (i_len == '0);
    quad       = phase[PHASE_WIDTH-1 -: 2];
    idx        = phase[PHASE_WIDTH-3 -: LUT_ADDR];
    addr       = quad[0] ? ~idx : idx;
    lvl        = '0;
    case (mode)
      MODE_IMPULSE: lvl = (k == '0) ? amp : '0;
      MODE_STEP:    lvl = amp;
      default:      lvl = '0;
    endcase
    sine_val = s1_neg ? -{1'b0, mag} : {1'b0, mag};
  end

  // ROM register is pipeline stage 1 for the magnitude; quadrant sign travels alongside.
  sine_qlut #(
    .LUT_ADDR  (LUT_ADDR),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lut (
    .i_clk (i_clk),
    .i_addr(addr),
    .o_mag (mag)
  );

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state  <= ST_IDLE;
      mode   <= MODE_IMPULSE;
      amp    <= '0;
      phase  <= '0;
      finc   <= '0;
      fstep  <= '0;
      len    <= '0;
      k      <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= zero_start || (s1_valid && s1_last);
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            mode  <= mode_t'(i_mode);
            amp   <= i_amp;
            finc  <= i_finc;
            fstep <= i_fstep;
            len   <= i_len;
            phase <= '0;
            k     <= '0;
            if (i_len != '0) begin
              state  <= ST_RUN;
              o_busy <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_ce) begin
            k     <= k + LEN_WIDTH'(1);
            phase <= phase + finc;
            if (mode == MODE_CHIRP) finc <= finc + fstep;
            if (is_last) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (o_done) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sine  <= 1'b0;
      s1_neg   <= 1'b0;
      s1_lvl   <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
    end else begin
      s1_valid <= issue;
      s1_last  <= issue && is_last;
      s1_sine  <= (mode == MODE_TONE) || (mode == MODE_CHIRP);
      s1_neg   <= quad[1];
      s1_lvl   <= lvl;
      o_valid  <= s1_valid;
      o_last   <= s1_valid && s1_last;
      if (s1_valid) o_data <= s1_sine ? sine_val : s1_lvl;
    end
  end

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed bench for fir_stim_gen with a closed-form sample model and per-cycle compare.
module tb_fir_stim_gen;

  localparam int DW = 18;
  localparam int PW = 24;
  localparam int LA = 8;
  localparam int LW = 16;

  logic                 clk = 1'b0;
  logic                 clr, ce, start;
  logic [1:0]           mode;
  logic signed [DW-1:0] amp;
  logic [PW-1:0]        finc, fstep;
  logic [LW-1:0]        len;
  logic signed [DW-1:0] data;
  logic                 valid, last, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int zl_cyc = -1;
  int first_v = -1;
  int done_cyc = -1;
  int lut [256];
  bit vlog [4096];
  bit blog [4096];

  typedef struct {
    longint d;
    bit     l;
  } exp_t;
  exp_t   exp_q [$];
  longint rx_log [$];

  fir_stim_gen #(
    .DATA_WIDTH (DW),
    .PHASE_WIDTH(PW),
    .LUT_ADDR   (LA),
    .LEN_WIDTH  (LW)
  ) dut (
    .i_clk  (clk),
    .i_clr  (clr),
    .i_ce   (ce),
    .i_start(start),
    .i_mode (mode),
    .i_amp  (amp),
    .i_finc (finc),
    .i_fstep(fstep),
    .i_len  (len),
    .o_data (data),
    .o_valid(valid),
    .o_last (last),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Sample k straight from the burst definition: phase_k = k*finc + fstep*k(k-1)/2.
  function automatic longint model_sample(input int m, input longint a, input longint fi,
                                          input longint fs, input longint kk);
    longint unsigned ph;
    int q, i, mg;
    if (m == 0) return (kk == 0) ? a : 0;
    if (m == 1) return a;
    if (m == 2) ph = kk * fi;
    else        ph = kk * fi + fs * ((kk * (kk - 1)) / 2);
    ph = ph & 64'hFF_FFFF;
    q  = int'(ph >> 22);
    i  = int'((ph >> 14) & 64'hFF);
    mg = (q % 2 == 1) ? lut[255 - i] : lut[i];
    return (q >= 2) ? -mg : mg;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    if (mon_en) begin
      exp_done = (cyc == zl_cyc);
      if (cyc < 4096) begin
        vlog[cyc] = valid;
        blog[cyc] = busy;
      end
      if (valid) begin
        rx_log.push_back(data);
        if (first_v < 0) first_v = cyc;
        if (exp_q.size() == 0) check("spurious_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("data", data, e.d);
          check("last", last, e.l);
          exp_done = exp_done | e.l;
        end
      end else begin
        check("last_without_valid", last, 0);
      end
      if (done) done_cyc = cyc;
      check("done", done, exp_done);
    end
  end

  task automatic burst(input int m, input longint a, input longint fi, input longint fs,
                       input int n, output int scyc);
    exp_t e;
    @(posedge clk); #1;
    mode  = 2'(m);
    amp   = DW'(a);
    finc  = PW'(fi);
    fstep = PW'(fs);
    len   = LW'(n);
    start = 1'b1;
    scyc  = cyc;
    rx_log.delete();
    first_v  = -1;
    done_cyc = -1;
    for (int kk = 0; kk < n; kk++) begin
      e.d = model_sample(m, a, fi, fs, kk);
      e.l = (kk == n - 1);
      exp_q.push_back(e);
    end
    if (n == 0) zl_cyc = scyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 400) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic check_rx(input string name, input longint e0, input longint e1,
                          input longint e2, input longint e3);
    longint ev [4];
    ev = '{e0, e1, e2, e3};
    check({name, "_count"}, rx_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_log.size()) check($sformatf("%s_s%0d", name, i), rx_log[i], ev[i]);
  endtask

  initial begin
    int s;
    bit pat [9];
    for (int i = 0; i < 256; i++)
      lut[i] = $rtoi(131071.0 * $sin(3.14159265358979323846 * (2.0 * i + 1.0) / 1024.0) + 0.5);

    clr = 1'b1; ce = 1'b1; start = 1'b0; mode = '0; amp = '0;
    finc = '0; fstep = '0; len = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    mon_en = 1'b1;

    // 1: impulse timing
    burst(0, 1000, 0, 0, 4, s);
    wait_idle("impulse");
    check_rx("impulse", 1000, 0, 0, 0);
    check("impulse_latency", first_v - s, 3);
    check("impulse_done_cycle", done_cyc - s, 6);
    check("impulse_busy_at_done", blog[done_cyc], 1);
    check("impulse_busy_after", blog[done_cyc + 1], 0);

    // 2: tone, quarter-period steps
    burst(2, 0, 64'd1 << 22, 0, 4, s);
    wait_idle("tone");
    check_rx("tone", 402, 131070, -402, -131070);

    // 3: chirp from zero frequency
    burst(3, 0, 0, 64'd1 << 22, 4, s);
    wait_idle("chirp");
    check_rx("chirp", 402, 402, 131070, -131070);

    // 4: step with stalls
    pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
    burst(1, -5, 0, 0, 6, s);
    ce = pat[0];
    for (int j = 1; j < 9; j++) begin
      @(posedge clk); #1;
      ce = pat[j];
    end
    @(posedge clk); #1;
    ce = 1'b1;
    wait_idle("step");
    for (int j = 0; j < 9; j++) check($sformatf("step_valid_slot%0d", j), vlog[s + 3 + j], pat[j]);
    check("step_count", rx_log.size(), 6);
    check("step_done_cycle", done_cyc - s, 11);

    // 5: clear mid-burst, then restart
    burst(2, 0, 64'd1 << 22, 0, 100, s);
    for (int n = 0; n < 200 && rx_log.size() < 10; n++) @(negedge clk);
    check("clr_reached_10", rx_log.size() >= 10, 1);
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("clr_data", data, 0);
    check("clr_valid", valid, 0);
    check("clr_last", last, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    repeat (4) @(negedge clk);
    burst(2, 0, 64'd1 << 22, 0, 4, s);
    wait_idle("restart");
    check_rx("restart", 402, 131070, -402, -131070);

    // 6: zero-length burst, then start ignored while busy
    burst(0, 77, 0, 0, 0, s);
    repeat (4) @(negedge clk);
    check("zero_len_done_seen", done_cyc - s, 1);
    check("zero_len_samples", rx_log.size(), 0);
    burst(1, 33, 0, 0, 8, s);
    @(posedge clk); #1;
    mode = 2'b00; amp = 18'sd9; len = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("ignored_start");
    repeat (6) @(negedge clk);
    check("ignored_start_count", rx_log.size(), 8);
    check("ignored_start_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
